// File: rtl/pixel_write_ctrl_if.sv
// ============================================================================
// Module   : pixel_write_ctrl_if
// Brief    : Host write / display release bus for the ping-pong pixel writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pixel_write_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              CSDisplay;
    logic [9:0]        AIP;
    logic [9:0]        AIL;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic              wready;
    logic              Buf0Release;
    logic              Buf1Release;
    logic              WE0;
    logic              WE1;
    logic [ADDR_W-1:0] WAddr;
    logic [DATA_W-1:0] WDataOut;
    logic              Buf0Full;
    logic              Buf1Full;
    logic              FrameDone;
    logic              Overflow;

    modport master (
        output CSDisplay, AIP, AIL, wvalid, wdata, Buf0Release, Buf1Release,
        input  wready, WE0, WE1, WAddr, WDataOut, Buf0Full, Buf1Full,
               FrameDone, Overflow
    );

    modport slave (
        input  CSDisplay, AIP, AIL, wvalid, wdata, Buf0Release, Buf1Release,
        output wready, WE0, WE1, WAddr, WDataOut, Buf0Full, Buf1Full,
               FrameDone, Overflow
    );
endinterface

`default_nettype wire

// File: rtl/pixel_write_ctrl.sv
// ============================================================================
// Module   : pixel_write_ctrl
// Brief    : Host-side write controller feeding ping-pong pixel buffers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_write_ctrl #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pixel_write_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL0 = 3'd1,
        S_FILL1 = 3'd2,
        S_WAIT0 = 3'd3,
        S_WAIT1 = 3'd4
    } state_t;

    state_t            r_state;
    logic [19:0]       r_count;
    logic [19:0]       r_frame_n;
    logic              r_buf0_full;
    logic              r_buf1_full;
    logic              r_we0;
    logic              r_we1;
    logic              r_frame_done;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic [19:0]       w_frame_n;
    logic              w_filling;
    logic              w_waiting;
    logic              w_wready;
    logic              w_xfer;
    logic              w_last;

    assign w_frame_n = 20'(bus.AIP) * 20'(bus.AIL);
    assign w_filling = (r_state == S_FILL0) || (r_state == S_FILL1);
    assign w_waiting = (r_state == S_WAIT0) || (r_state == S_WAIT1);
    assign w_wready  = bus.CSDisplay & w_filling;
    assign w_xfer    = bus.wvalid & w_wready;
    assign w_last    = w_xfer && (r_count == (r_frame_n - 20'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= 20'd0;
            r_frame_n    <= 20'd0;
            r_buf0_full  <= 1'b0;
            r_buf1_full  <= 1'b0;
            r_we0        <= 1'b0;
            r_we1        <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_we0        <= w_xfer && (r_state == S_FILL0);
            r_we1        <= w_xfer && (r_state == S_FILL1);
            r_frame_done <= w_last;

            if (w_xfer) begin
                r_waddr <= ADDR_W'(r_count);
                r_wdata <= bus.wdata;
                r_count <= r_count + 20'd1;
            end

            // Completing a frame outranks a same-cycle release of that buffer
            if (w_last && (r_state == S_FILL0)) begin
                r_buf0_full <= 1'b1;
            end else if (bus.Buf0Release) begin
                r_buf0_full <= 1'b0;
            end

            if (w_last && (r_state == S_FILL1)) begin
                r_buf1_full <= 1'b1;
            end else if (bus.Buf1Release) begin
                r_buf1_full <= 1'b0;
            end

            if (w_waiting && bus.wvalid && bus.CSDisplay) begin
                r_overflow <= 1'b1;
            end

            // Every entry into a fill restarts the count and re-samples the frame size
            case (r_state)
                S_IDLE: begin
                    if (bus.CSDisplay && (w_frame_n != 20'd0)) begin
                        r_state   <= S_FILL0;
                        r_count   <= 20'd0;
                        r_frame_n <= w_frame_n;
                    end
                end
                S_FILL0: begin
                    if (w_last) begin
                        r_count <= 20'd0;
                        if (!r_buf1_full) begin
                            r_state   <= S_FILL1;
                            r_frame_n <= w_frame_n;
                        end else begin
                            r_state <= S_WAIT1;
                        end
                    end
                end
                S_FILL1: begin
                    if (w_last) begin
                        r_count <= 20'd0;
                        if (!r_buf0_full) begin
                            r_state   <= S_FILL0;
                            r_frame_n <= w_frame_n;
                        end else begin
                            r_state <= S_WAIT0;
                        end
                    end
                end
                S_WAIT0: begin
                    if (!r_buf0_full) begin
                        r_state   <= S_FILL0;
                        r_count   <= 20'd0;
                        r_frame_n <= w_frame_n;
                    end
                end
                S_WAIT1: begin
                    if (!r_buf1_full) begin
                        r_state   <= S_FILL1;
                        r_count   <= 20'd0;
                        r_frame_n <= w_frame_n;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wready    = w_wready;
    assign bus.WE0       = r_we0;
    assign bus.WE1       = r_we1;
    assign bus.WAddr     = r_waddr;
    assign bus.WDataOut  = r_wdata;
    assign bus.Buf0Full  = r_buf0_full;
    assign bus.Buf1Full  = r_buf1_full;
    assign bus.FrameDone = r_frame_done;
    assign bus.Overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_ctrl.sv
// ============================================================================
// Module   : tb_pixel_write_ctrl
// Brief    : Directed bench for pixel_write_ctrl with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pixel_write_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   done    = 1'b0;

    always #5 clk = ~clk;

    pixel_write_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bus ();

    pixel_write_ctrl #(.ADDR_W(20), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: which buffer is the target, whether we are idle or
    // stalled waiting for it, and the expected registered outputs.
    bit        m_idle, m_wait;
    int        m_buf, m_cnt, m_n;
    bit        m_full[2];
    bit        m_we[2];
    bit        m_fd, m_ovf;
    int        m_addr;
    bit [31:0] m_data;

    task automatic m_reset();
        m_idle = 1; m_wait = 0; m_buf = 0; m_cnt = 0; m_n = 0;
        m_full[0] = 0; m_full[1] = 0; m_we[0] = 0; m_we[1] = 0;
        m_fd = 0; m_ovf = 0; m_addr = 0; m_data = '0;
    endtask

    task automatic m_step();
        bit set[2];
        int sz;
        set[0] = 0; set[1] = 0;
        sz = int'(bus.AIP) * int'(bus.AIL);
        m_we[0] = 0; m_we[1] = 0; m_fd = 0;
        if (m_idle) begin
            if (bus.CSDisplay && sz != 0) begin
                m_idle = 0; m_buf = 0; m_cnt = 0; m_n = sz;
            end
        end else if (m_wait) begin
            if (bus.CSDisplay && bus.wvalid) m_ovf = 1;
            if (!m_full[m_buf]) begin
                m_wait = 0; m_cnt = 0; m_n = sz;
            end
        end else if (bus.CSDisplay && bus.wvalid) begin
            m_we[m_buf] = 1; m_addr = m_cnt; m_data = bus.wdata;
            m_cnt++;
            if (m_cnt == m_n) begin
                set[m_buf] = 1; m_fd = 1;
                m_buf = 1 - m_buf; m_cnt = 0; m_n = sz;
                if (m_full[m_buf]) m_wait = 1;
            end
        end
        if (set[0]) m_full[0] = 1; else if (bus.Buf0Release) m_full[0] = 0;
        if (set[1]) m_full[1] = 1; else if (bus.Buf1Release) m_full[1] = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else        m_step();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                check("wready",    64'(bus.wready),    64'(bus.CSDisplay && !m_idle && !m_wait));
                check("WE0",       64'(bus.WE0),       64'(m_we[0]));
                check("WE1",       64'(bus.WE1),       64'(m_we[1]));
                check("WAddr",     64'(bus.WAddr),     64'(m_addr));
                check("WDataOut",  64'(bus.WDataOut),  64'(m_data));
                check("Buf0Full",  64'(bus.Buf0Full),  64'(m_full[0]));
                check("Buf1Full",  64'(bus.Buf1Full),  64'(m_full[1]));
                check("FrameDone", 64'(bus.FrameDone), 64'(m_fd));
                check("Overflow",  64'(bus.Overflow),  64'(m_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d);
        bus.wvalid = 1'b1;
        bus.wdata  = d;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        bus.CSDisplay = 1'b1; bus.AIP = 10'd4; bus.AIL = 10'd2;
        bus.wvalid = 1'b1; bus.wdata = 32'hDEAD;
        bus.Buf0Release = 1'b0; bus.Buf1Release = 1'b0;

        // Reset held with wvalid high
        repeat (3) tick();
        at_neg();
        check("rst_wready", 64'(bus.wready), 64'd0);
        check("rst_we0",    64'(bus.WE0),    64'd0);
        check("rst_waddr",  64'(bus.WAddr),  64'd0);
        check("rst_ovf",    64'(bus.Overflow), 64'd0);
        reset = 1'b1; bus.wvalid = 1'b0;
        tick();
        at_neg();
        check("fill0_ready", 64'(bus.wready), 64'd1);

        // First 4x2 frame into Buf0
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(i));
        at_neg();
        check("f0_we0",   64'(bus.WE0),       64'd1);
        check("f0_addr",  64'(bus.WAddr),     64'd7);
        check("f0_data",  64'(bus.WDataOut),  64'h107);
        check("f0_full",  64'(bus.Buf0Full),  64'd1);
        check("f0_done",  64'(bus.FrameDone), 64'd1);
        send(32'h200);
        at_neg();
        check("f1_we1",   64'(bus.WE1),   64'd1);
        check("f1_we0",   64'(bus.WE0),   64'd0);
        check("f1_addr0", 64'(bus.WAddr), 64'd0);

        // Fill Buf1 with nothing released: stall on Buf0
        for (int i = 1; i < 8; i++) send(32'h200 + 32'(i));
        at_neg();
        check("stall_full1",  64'(bus.Buf1Full), 64'd1);
        check("stall_wready", 64'(bus.wready),   64'd0);
        tick();
        at_neg();
        check("stall_ovf", 64'(bus.Overflow), 64'd1);
        bus.wvalid = 1'b0; bus.Buf0Release = 1'b1;
        tick();
        bus.Buf0Release = 1'b0;
        at_neg();
        check("rel0_full",   64'(bus.Buf0Full), 64'd0);
        check("rel0_wready", 64'(bus.wready),   64'd0);
        tick();
        at_neg();
        check("resume_wready", 64'(bus.wready), 64'd1);
        send(32'h300);
        at_neg();
        check("resume_we0",  64'(bus.WE0),   64'd1);
        check("resume_addr", 64'(bus.WAddr), 64'd0);
        send(32'h301);
        send(32'h302);

        // Chip-select pause with wvalid still high; Buf1 released meanwhile
        bus.CSDisplay = 1'b0; bus.Buf1Release = 1'b1;
        tick();
        bus.Buf1Release = 1'b0;
        repeat (4) tick();
        at_neg();
        check("cs_wready", 64'(bus.wready),   64'd0);
        check("cs_we0",    64'(bus.WE0),      64'd0);
        check("cs_addr",   64'(bus.WAddr),    64'd2);
        check("cs_full1",  64'(bus.Buf1Full), 64'd0);
        check("cs_ovf_kept", 64'(bus.Overflow), 64'd1);
        bus.CSDisplay = 1'b1;
        send(32'h303);
        at_neg();
        check("cs_resume_we0",  64'(bus.WE0),   64'd1);
        check("cs_resume_addr", 64'(bus.WAddr), 64'd3);

        // Frame size change mid-fill only affects the next fill
        bus.AIP = 10'd1;
        for (int i = 4; i < 8; i++) send(32'h300 + 32'(i));
        at_neg();
        check("latch_done", 64'(bus.FrameDone), 64'd1);
        check("latch_addr", 64'(bus.WAddr),     64'd7);
        check("latch_full", 64'(bus.Buf0Full),  64'd1);
        send(32'h400);
        at_neg();
        check("small_nodone", 64'(bus.FrameDone), 64'd0);
        send(32'h401);
        at_neg();
        check("small_done",  64'(bus.FrameDone), 64'd1);
        check("small_we1",   64'(bus.WE1),       64'd1);
        check("small_addr",  64'(bus.WAddr),     64'd1);
        check("small_full1", 64'(bus.Buf1Full),  64'd1);
        bus.wvalid = 1'b0;

        // Zero-size frame keeps the controller idle
        reset = 1'b0;
        tick();
        at_neg();
        check("zr_full0", 64'(bus.Buf0Full), 64'd0);
        check("zr_ovf",   64'(bus.Overflow), 64'd0);
        bus.AIP = 10'd0;
        reset = 1'b1;
        repeat (3) tick();
        at_neg();
        check("zero_wready", 64'(bus.wready), 64'd0);

        // Async reset in the middle of the Buf1 fill
        bus.AIP = 10'd4;
        tick();
        at_neg();
        check("z_fill0_ready", 64'(bus.wready), 64'd1);
        for (int i = 0; i < 8; i++) send(32'h500 + 32'(i));
        for (int i = 0; i < 5; i++) send(32'h600 + 32'(i));
        at_neg();
        check("mid_we1",  64'(bus.WE1),   64'd1);
        check("mid_addr", 64'(bus.WAddr), 64'd4);
        reset = 1'b0; bus.wvalid = 1'b0;
        #1;
        check("arst_full0", 64'(bus.Buf0Full), 64'd0);
        check("arst_full1", 64'(bus.Buf1Full), 64'd0);
        check("arst_we1",   64'(bus.WE1),      64'd0);
        check("arst_addr",  64'(bus.WAddr),    64'd0);
        tick();
        reset = 1'b1;
        tick();
        send(32'h700);
        at_neg();
        check("restart_we0",  64'(bus.WE0),      64'd1);
        check("restart_addr", 64'(bus.WAddr),    64'd0);
        check("restart_data", 64'(bus.WDataOut), 64'h700);
        bus.wvalid = 1'b0;
        tick();
        at_neg();

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
